counter_chain_modn: RTL and testbench



---
 rtl/counter_chain_modn_pkg.sv | 11 +
 rtl/counter_chain_modn_if.sv | 14 +
 rtl/counter_chain_modn_digit.sv | 32 +++
 rtl/counter_chain_modn.sv | 66 ++++++
 tb/tb_counter_chain_modn.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/counter_chain_modn_pkg.sv
// Shared timer constants and helpers for the cascaded digit counters.
package timer_pkg;
  localparam int DIGIT_W = 4;

  // mm:ss display: digit0 mod 10, digit1 mod 6, digit2 mod 10, digit3 mod 6
  localparam logic [15:0] MODS_MMSS = {4'd6, 4'd10, 4'd6, 4'd10};

  function automatic logic [DIGIT_W-1:0] max_digit(input logic [DIGIT_W-1:0] modulus);
    return modulus - 4'd1;
  endfunction
endpackage

// File: rtl/counter_chain_modn_if.sv
// Control/data bundle between a counter chain and whatever drives it.
interface counter_chain_modn_if #(parameter int DIGITS = 4);
  logic                  en;
  logic                  loadn;
  logic                  up;
  logic [4*DIGITS-1:0]   data;
  logic [4*DIGITS-1:0]   digits;
  logic                  zero;
  logic                  tc;
  logic                  done;

  modport master (output en, loadn, up, data, input digits, zero, tc, done);
  modport slave  (input en, loadn, up, data, output digits, zero, tc, done);
endinterface

// File: rtl/counter_chain_modn_digit.sv
// One modulo-MOD digit: clamped parallel load, up/down step with wrap.
module counter_digit_modn
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MOD = 4'd10
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               en,
  input  logic               up,
  input  logic               loadn,
  input  logic [DIGIT_W-1:0] data,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_min,
  output logic               at_max
);
  localparam logic [DIGIT_W-1:0] MAX = max_digit(MOD);

  assign at_min = (digit == '0);
  assign at_max = (digit == MAX);

  always_ff @(posedge clock) begin
    if (clear) begin
      digit <= '0;
    end else if (!loadn) begin
      digit <= (data >= MOD) ? MAX : data;
    end else if (en) begin
      if (up) digit <= at_max ? '0 : digit + 4'd1;
      else    digit <= at_min ? MAX : digit - 4'd1;
    end
  end
endmodule

// File: rtl/counter_chain_modn.sv
// Cascaded modulo-N digit counter with carry/borrow chain, terminal hold and done pulse.
module counter_chain_modn
  import timer_pkg::*;
#(
  parameter int                  DIGITS = 4,
  parameter logic [4*DIGITS-1:0] MODS   = MODS_MMSS,
  parameter bit                  WRAP   = 1'b0
) (
  input logic           clock,
  input logic           clear,
  counter_chain_modn_if.slave bus
);
  logic [DIGITS-1:0]   at_min;
  logic [DIGITS-1:0]   at_max;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] digits_q;
  logic                at_term;
  logic                step;
  logic                near_up;
  logic                near_dn;
  logic                done_q;

  // carry[i] = every digit below i is at its rollover value for the current direction
  assign carry[0] = 1'b1;
  assign at_term  = carry[DIGITS];
  assign step     = bus.en & (WRAP | ~at_term);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [DIGIT_W-1:0] M = MODS[4*i +: 4];

    assign carry[i+1] = carry[i] & (bus.up ? at_max[i] : at_min[i]);

    counter_digit_modn #(.MOD(M)) u_digit (
      .clock  (clock),
      .clear  (clear),
      .en     (step & carry[i]),
      .up     (bus.up),
      .loadn  (bus.loadn),
      .data   (bus.data[4*i +: 4]),
      .digit  (digits_q[4*i +: 4]),
      .at_min (at_min[i]),
      .at_max (at_max[i])
    );
  end

  // One step away from terminal: only digit 0 differs from the terminal value, by one
  always_comb begin
    near_up = (digits_q[3:0] == max_digit(MODS[3:0]) - 4'd1);
    near_dn = (digits_q[3:0] == 4'd1);
    for (int i = 1; i < DIGITS; i++) begin
      near_up = near_up & at_max[i];
      near_dn = near_dn & at_min[i];
    end
  end

  always_ff @(posedge clock) begin
    if (clear)           done_q <= 1'b0;
    else if (!bus.loadn) done_q <= 1'b0;
    else                 done_q <= step & (bus.up ? near_up : near_dn);
  end

  assign bus.digits = digits_q;
  assign bus.zero   = &at_min;
  assign bus.tc     = bus.en & at_term;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_counter_chain_modn.sv
// Scoreboard bench: stimulus queues expected post-edge state, a negedge monitor compares.
module tb_counter_chain_modn;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        loadn = 1'b1;
  logic        en    = 1'b0;
  logic        up    = 1'b0;
  logic [15:0] data  = 16'h0000;
  int          cyc   = 0;
  int          total = 0;
  int          passed = 0;

  typedef struct {
    int          sel;
    int          target;
    string       name;
    logic [15:0] dig;
    logic        zero;
    logic        tc;
    logic        done;
  } exp_t;

  exp_t q[$];
  exp_t e;

  counter_chain_modn_if #(.DIGITS(4)) if0 ();
  counter_chain_modn_if #(.DIGITS(4)) if1 ();

  assign if0.en = en;  assign if0.loadn = loadn;  assign if0.up = up;  assign if0.data = data;
  assign if1.en = en;  assign if1.loadn = loadn;  assign if1.up = up;  assign if1.data = data;

  counter_chain_modn #(.DIGITS(4), .MODS(16'h6A6A), .WRAP(1'b0)) dut0 (
    .clock(clock), .clear(clear), .bus(if0));
  counter_chain_modn #(.DIGITS(4), .MODS(16'h6A6A), .WRAP(1'b1)) dut1 (
    .clock(clock), .clear(clear), .bus(if1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].target <= cyc) begin
      e = q.pop_front();
      if (e.target < cyc) begin
        check({e.name, "_stale"}, 16'(cyc), 16'(e.target));
      end else if (e.sel == 0) begin
        check({e.name, "_digits"}, if0.digits, e.dig);
        check({e.name, "_zero"}, 16'(if0.zero), 16'(e.zero));
        check({e.name, "_tc"},   16'(if0.tc),   16'(e.tc));
        check({e.name, "_done"}, 16'(if0.done), 16'(e.done));
      end else begin
        check({e.name, "_digits"}, if1.digits, e.dig);
        check({e.name, "_zero"}, 16'(if1.zero), 16'(e.zero));
        check({e.name, "_tc"},   16'(if1.tc),   16'(e.tc));
        check({e.name, "_done"}, 16'(if1.done), 16'(e.done));
      end
    end
  end

  task automatic drive(input logic c, input logic l, input logic n, input logic u,
                       input logic [15:0] d);
    @(negedge clock);
    #1;
    clear = c; loadn = l; en = n; up = u; data = d;
  endtask

  task automatic expect_state(input int sel, input string name, input logic [15:0] dg,
                              input logic z, input logic t, input logic dn);
    exp_t x;
    x.sel = sel; x.target = cyc + 1; x.name = name;
    x.dig = dg; x.zero = z; x.tc = t; x.done = dn;
    q.push_back(x);
  endtask

  initial begin
    // reset, tc after clear follows en && !up
    drive(1, 1, 0, 0, 16'h0000); expect_state(0, "rst0", 16'h0000, 1, 0, 0);
                                 expect_state(1, "rst1", 16'h0000, 1, 0, 0);
    drive(1, 1, 1, 0, 16'h0000); expect_state(0, "rst_tc", 16'h0000, 1, 1, 0);

    // 01:00 down one step borrows through three digits
    drive(0, 0, 0, 0, 16'h0100); expect_state(0, "load0100", 16'h0100, 0, 0, 0);
    drive(0, 1, 1, 0, 16'h0100); expect_state(0, "dn0059",   16'h0059, 0, 0, 0);

    // 00:02 down to terminal, single done pulse, then hold
    drive(0, 0, 0, 0, 16'h0002); expect_state(0, "load0002", 16'h0002, 0, 0, 0);
    drive(0, 1, 1, 0, 16'h0002); expect_state(0, "dn0001",   16'h0001, 0, 0, 0);
    drive(0, 1, 1, 0, 16'h0002); expect_state(0, "dn0000",   16'h0000, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 16'h0002); expect_state(0, "hold0000", 16'h0000, 1, 1, 0);
    end

    // wrap vs hold at 00:00
    drive(0, 0, 0, 0, 16'h0000); expect_state(1, "w_load0",  16'h0000, 1, 0, 0);
    drive(0, 1, 1, 0, 16'h0000); expect_state(1, "w_dn5959", 16'h5959, 0, 0, 0);
                                 expect_state(0, "h_dn0000", 16'h0000, 1, 1, 0);
    drive(0, 1, 1, 1, 16'h0000); expect_state(1, "w_up0000", 16'h0000, 1, 0, 0);
                                 expect_state(0, "h_up0001", 16'h0001, 0, 0, 0);

    // per-digit clamp, then hold at up terminal
    drive(0, 0, 0, 1, 16'hFF7C); expect_state(0, "clamp",    16'h5959, 0, 0, 0);
    drive(0, 1, 1, 1, 16'hFF7C); expect_state(0, "uphold1",  16'h5959, 0, 1, 0);
    drive(0, 1, 1, 1, 16'hFF7C); expect_state(0, "uphold2",  16'h5959, 0, 1, 0);

    // load beats count, clear beats load
    drive(0, 0, 1, 1, 16'h0305); expect_state(0, "loadwins", 16'h0305, 0, 0, 0);
    drive(1, 0, 0, 1, 16'h0305); expect_state(0, "clrwins",  16'h0000, 1, 0, 0);

    // clear mid-count, resume from zero
    drive(0, 0, 0, 0, 16'h0230); expect_state(0, "load0230", 16'h0230, 0, 0, 0);
    drive(0, 1, 1, 0, 16'h0230); expect_state(0, "dn0229",   16'h0229, 0, 0, 0);
    drive(1, 1, 1, 0, 16'h0230); expect_state(0, "midclr",   16'h0000, 1, 1, 0);
    drive(0, 1, 1, 1, 16'h0230); expect_state(0, "resume",   16'h0001, 0, 0, 0);

    // up into terminal pulses done; direction change steps back down
    drive(0, 0, 0, 1, 16'h5958); expect_state(0, "load5958", 16'h5958, 0, 0, 0);
    drive(0, 1, 1, 1, 16'h5958); expect_state(0, "up5959",   16'h5959, 0, 1, 1);
    drive(0, 1, 1, 1, 16'h5958); expect_state(0, "uphold3",  16'h5959, 0, 1, 0);
    drive(0, 1, 1, 0, 16'h5958); expect_state(0, "dir5958",  16'h5958, 0, 0, 0);

    drive(0, 1, 0, 0, 16'h0000);
    repeat (3) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
